// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment bit 0 is 'a' and bit 6 is 'g'. A 1 lights the segment.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int N_DIGITS_MIN = 2;
    localparam int N_DIGITS_MAX = 8;
    localparam int SCAN_DIV_MIN = 4;
    localparam int DEAD_MIN     = 1;

endpackage

// File: rtl/seg_dec.sv
// Hex nibble to 7-segment pattern decoder (purely combinational).
module seg_dec
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] iNibble,
    output logic [6:0] oSeg
);

    // Table lookup of the segment pattern for one nibble
    always_comb begin
        case (iNibble)
            4'h0:    oSeg = SEG_0;
            4'h1:    oSeg = SEG_1;
            4'h2:    oSeg = SEG_2;
            4'h3:    oSeg = SEG_3;
            4'h4:    oSeg = SEG_4;
            4'h5:    oSeg = SEG_5;
            4'h6:    oSeg = SEG_6;
            4'h7:    oSeg = SEG_7;
            4'h8:    oSeg = SEG_8;
            4'h9:    oSeg = SEG_9;
            4'hA:    oSeg = SEG_A;
            4'hB:    oSeg = SEG_B;
            4'hC:    oSeg = SEG_C;
            4'hD:    oSeg = SEG_D;
            4'hE:    oSeg = SEG_E;
            4'hF:    oSeg = SEG_F;
            default: oSeg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with double-buffered frames,
// per-slot dead time, per-digit blanking and leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    iLoad,
    input  logic [4*N_DIGITS-1:0]   iHexBus,
    input  logic [N_DIGITS-1:0]     iBlank,
    input  logic                    iLzs,
    output logic                    oPending,
    output logic                    oFrame,
    output logic [N_DIGITS-1:0]     oDIGIT,
    output logic [6:0]              oSEG7
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]       DEAD_END   = PW'(DEAD);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] DIG_ONE    = N_DIGITS'(1);

    if (N_DIGITS < N_DIGITS_MIN || N_DIGITS > N_DIGITS_MAX) begin : g_bad_digits
        $error("seg7_scan_driver: N_DIGITS out of range");
    end
    if (SCAN_DIV < SCAN_DIV_MIN || DEAD < DEAD_MIN || DEAD >= SCAN_DIV) begin : g_bad_timing
        $error("seg7_scan_driver: SCAN_DIV/DEAD out of range");
    end

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0]   pend_mask_q, pend_mask_d;
    logic                  pend_q, pend_d;
    logic [4*N_DIGITS-1:0] disp_data_q, disp_data_d;
    logic [N_DIGITS-1:0]   disp_mask_q, disp_mask_d;
    logic                  frame_q, frame_d;
    logic [N_DIGITS-1:0]   digit_q, digit_d;
    logic [6:0]            seg_q, seg_d;

    logic                  tick_s;
    logic                  boundary_s;
    logic [3:0]            nib_s;
    logic [6:0]            dec_seg_s;
    logic [N_DIGITS-1:0]   lz_sup_s;
    logic                  blank_s;

    assign tick_s     = (presc_q == PRESC_LAST);
    assign boundary_s = tick_s && (idx_q == IDX_LAST);

    // Prescaler and digit index advance
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (tick_s) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Pending/display buffers: a load on the boundary bypasses the pending stage
    always_comb begin
        pend_data_d = pend_data_q;
        pend_mask_d = pend_mask_q;
        pend_d      = pend_q;
        disp_data_d = disp_data_q;
        disp_mask_d = disp_mask_q;
        frame_d     = boundary_s;
        if (iLoad && boundary_s) begin
            disp_data_d = iHexBus;
            disp_mask_d = iBlank;
            pend_d      = 1'b0;
        end else if (iLoad) begin
            pend_data_d = iHexBus;
            pend_mask_d = iBlank;
            pend_d      = 1'b1;
        end else if (boundary_s && pend_q) begin
            disp_data_d = pend_data_q;
            disp_mask_d = pend_mask_q;
            pend_d      = 1'b0;
        end else begin
            pend_d      = pend_q;
        end
    end

    // Leading-zero run from the top digit; digit 0 is always shown
    always_comb begin : lzs_scan
        logic zero_run;
        lz_sup_s = '0;
        zero_run = iLzs;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (disp_data_q[4*k +: 4] == 4'h0);
            lz_sup_s[k] = zero_run;
        end
    end

    assign nib_s   = disp_data_q[{idx_q, 2'b00} +: 4];
    assign blank_s = disp_mask_q[idx_q] | lz_sup_s[idx_q];

    seg_dec u_seg_dec (
        .iNibble (nib_s),
        .oSeg    (dec_seg_s)
    );

    // Next registered drive for the digit and segment pins
    always_comb begin
        if (presc_q < DEAD_END) begin
            digit_d = '0;
            seg_d   = SEG_BLANK;
        end else begin
            digit_d = DIG_ONE << idx_q;
            seg_d   = blank_s ? SEG_BLANK : dec_seg_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_mask_q <= '0;
            pend_q      <= 1'b0;
            disp_data_q <= '0;
            disp_mask_q <= '0;
            frame_q     <= 1'b0;
            digit_q     <= '0;
            seg_q       <= SEG_BLANK;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_mask_q <= pend_mask_d;
            pend_q      <= pend_d;
            disp_data_q <= disp_data_d;
            disp_mask_q <= disp_mask_d;
            frame_q     <= frame_d;
            digit_q     <= digit_d;
            seg_q       <= seg_d;
        end
    end

    assign oPending = pend_q;
    assign oFrame   = frame_q;
    assign oDIGIT   = digit_q;
    assign oSEG7    = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=8, DEAD=2):
// vector table, hand-written corner sequences and a per-cycle reference model.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int DD = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iLoad;
    logic [15:0] iHexBus;
    logic [3:0]  iBlank;
    logic        iLzs;
    logic        oPending;
    logic        oFrame;
    logic [3:0]  oDIGIT;
    logic [6:0]  oSEG7;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(SD), .DEAD(DD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .iLoad    (iLoad),
        .iHexBus  (iHexBus),
        .iBlank   (iBlank),
        .iLzs     (iLzs),
        .oPending (oPending),
        .oFrame   (oFrame),
        .oDIGIT   (oDIGIT),
        .oSEG7    (oSEG7)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycle count since reset release plus the two buffers
    int          cyc;
    logic [15:0] m_disp, m_pbuf;
    logic [3:0]  m_dmask, m_pmask;
    logic        m_pend;
    logic [3:0]  e_digit;
    logic [6:0]  e_seg;
    logic        e_frame, e_pend;
    logic        saw_one;
    logic [7:0]  frame_seg [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_disp  = 16'h0;
        m_pbuf  = 16'h0;
        m_dmask = 4'h0;
        m_pmask = 4'h0;
        m_pend  = 1'b0;
    endtask

    function automatic logic m_blanked(input int d);
        if (m_dmask[d]) return 1'b1;
        if (iLzs && d != 0) begin
            for (int j = d; j < N; j++) begin
                if (m_disp[4*j +: 4] != 4'h0) return 1'b0;
            end
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: predict from the model, advance it, then compare on the falling edge
    task automatic step();
        int  presc, idx;
        logic bnd;
        @(posedge clk);
        presc = cyc % SD;
        idx   = (cyc / SD) % N;
        bnd   = ((cyc % (SD*N)) == SD*N - 1);
        if (presc < DD) begin
            e_digit = 4'h0;
            e_seg   = 7'h00;
        end else begin
            e_digit = 4'(1 << idx);
            e_seg   = m_blanked(idx) ? 7'h00 : segtab[m_disp[4*idx +: 4]];
        end
        e_frame = bnd;
        if (iLoad && bnd) begin
            m_disp = iHexBus; m_dmask = iBlank; m_pend = 1'b0;
        end else if (iLoad) begin
            m_pbuf = iHexBus; m_pmask = iBlank; m_pend = 1'b1;
        end else if (bnd && m_pend) begin
            m_disp = m_pbuf; m_dmask = m_pmask; m_pend = 1'b0;
        end
        e_pend = m_pend;
        cyc++;
        @(negedge clk);
        chk("model_digit",   32'(oDIGIT),   32'(e_digit));
        chk("model_seg",     32'(oSEG7),    32'(e_seg));
        chk("model_frame",   32'(oFrame),   32'(e_frame));
        chk("model_pending", 32'(oPending), 32'(e_pend));
        if (oSEG7 == 7'h06) saw_one = 1'b1;
    endtask

    task automatic load(input logic [15:0] hex, input logic [3:0] blank);
        iHexBus = hex;
        iBlank  = blank;
        iLoad   = 1'b1;
        step();
        iLoad   = 1'b0;
    endtask

    // Step until the next edge is at phase 'ph' within the frame
    task automatic align(input int ph);
        int k;
        for (k = 0; k < 100 && (cyc % (SD*N)) != ph; k++) step();
        if ((cyc % (SD*N)) != ph) chk("align_timeout", 32'd0, 32'd1);
    endtask

    // Wait for oFrame, then record the segment shown in every digit slot of the next frame
    task automatic show_frame();
        logic got;
        got = 1'b0;
        for (int w = 0; w < 100 && !got; w++) begin
            step();
            if (oFrame) got = 1'b1;
        end
        if (!got) chk("frame_timeout", 32'd0, 32'd1);
        for (int d = 0; d < N; d++) frame_seg[d] = 8'hFF;
        for (int c = 0; c < SD*N; c++) begin
            step();
            for (int d = 0; d < N; d++) begin
                if (oDIGIT[d]) frame_seg[d] = {1'b0, oSEG7};
            end
        end
    endtask

    typedef struct packed {
        logic [15:0]     hex;
        logic [3:0]      blank;
        logic            lzs;
        logic [3:0][6:0] seg;   // expected per digit, [3] = most significant
    } vec_t;

    vec_t vecs [7];

    initial begin
        int frames;
        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}};
        vecs[1] = '{16'h0042, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h66, 7'h5B}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{16'h8888, 4'b0100, 1'b0, {7'h7F, 7'h00, 7'h7F, 7'h7F}};
        vecs[4] = '{16'h0042, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h66, 7'h5B}};
        vecs[5] = '{16'h0103, 4'b0000, 1'b1, {7'h00, 7'h06, 7'h3F, 7'h4F}};
        vecs[6] = '{16'h0000, 4'b1111, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}};

        reset_n = 1'b0;
        iLoad   = 1'b0;
        iHexBus = 16'h0;
        iBlank  = 4'h0;
        iLzs    = 1'b0;
        saw_one = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_digit",   32'(oDIGIT),   32'd0);
        chk("rst_seg",     32'(oSEG7),    32'd0);
        chk("rst_frame",   32'(oFrame),   32'd0);
        chk("rst_pending", 32'(oPending), 32'd0);
        reset_n = 1'b1;

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            iLzs = vecs[v].lzs;
            load(vecs[v].hex, vecs[v].blank);
            show_frame();
            for (int d = 0; d < N; d++) begin
                chk($sformatf("vec%0d_digit%0d", v, d), 32'(frame_seg[d]), {25'd0, vecs[v].seg[d]});
            end
        end

        // Two loads within one frame: last wins, the first is never shown
        iLzs = 1'b0;
        align(0);
        saw_one = 1'b0;
        load(16'h1111, 4'h0);
        repeat (3) step();
        chk("dbl_pend1", 32'(oPending), 32'd1);
        load(16'h2222, 4'h0);
        chk("dbl_pend2", 32'(oPending), 32'd1);
        show_frame();
        for (int d = 0; d < N; d++) chk("dbl_seg", 32'(frame_seg[d]), 32'h5B);
        chk("dbl_no_ones", 32'(saw_one), 32'd0);

        // Load exactly on the boundary cycle
        align(SD*N - 1);
        load(16'h5555, 4'h0);
        chk("bnd_pend",  32'(oPending), 32'd0);
        chk("bnd_frame", 32'(oFrame),   32'd1);
        frames = 0;
        for (int c = 0; c < SD*N - 1; c++) begin
            step();
            if (oFrame) frames++;
        end
        chk("bnd_single_pulse", 32'(frames), 32'd0);
        show_frame();
        chk("bnd_seg0", 32'(frame_seg[0]), 32'h6D);

        // Asynchronous reset mid-slot with data pending
        align(0);
        load(16'hABCD, 4'h0);
        repeat (10) step();
        chk("rstmid_pend", 32'(oPending), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_digit", 32'(oDIGIT),   32'd0);
        chk("rstmid_seg",   32'(oSEG7),    32'd0);
        chk("rstmid_pend0", 32'(oPending), 32'd0);
        chk("rstmid_frame", 32'(oFrame),   32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rel_dead0", 32'(oDIGIT), 32'd0);
        step();
        chk("rel_dead1", 32'(oDIGIT), 32'd0);
        step();
        chk("rel_digit0", 32'(oDIGIT), 32'd1);
        chk("rel_pend",   32'(oPending), 32'd0);
        repeat (2*SD*N) step();

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            iLoad   = ($urandom_range(0, 15) == 0);
            iHexBus = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            iBlank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 63) == 0) iLzs = ~iLzs;
            step();
        end
        iLoad = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, giving clock cycles per digit slot (>= 4).
REQ-003 The block SHALL have parameter DEAD, default 16, giving blanked cycles at the start of each slot (1 <= DEAD < SCAN_DIV).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  input  1  system clock, all state on rising edge.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: iLoad  input  1  one-cycle strobe that captures iHexBus and iBlank.
REQ-008 Port: iHexBus  input  4*N_DIGITS  hex nibbles; nibble k drives digit k, where digit 0 is least significant.
REQ-009 Port: iBlank  input  N_DIGITS  per-digit force-blank mask.
REQ-010 Port: iLzs  input  1  leading-zero suppression enable, sampled live.
REQ-011 Port: oPending  output  1  captured data waiting for the next frame boundary.
REQ-012 Port: oFrame  output  1  one-cycle pulse at each frame boundary.
REQ-013 Port: oDIGIT  output  N_DIGITS  one-hot active-high digit enable.
REQ-014 Port: oSEG7  output  7  segments a..g on bits 0..6; 1 means lit; encoding is identical to seg_dec.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1; tick occurs when prescaler = SCAN_DIV-1; on tick, prescaler returns to 0.
REQ-016 Digit index SHALL advance on tick and wrap from N_DIGITS-1 to 0.
REQ-017 Frame boundary SHALL be defined as a tick with index = N_DIGITS-1.
REQ-018 iLoad SHALL write the pending buffer (data and mask) and set oPending; if several loads occur before a boundary, the last load wins.
REQ-019 At a frame boundary with oPending=1, the pending buffer SHALL be copied to the display buffer and oPending SHALL clear.
REQ-020 If iLoad coincides with a frame boundary, the iLoad data SHALL go directly to the display buffer and oPending SHALL be 0 the next cycle.
REQ-021 The display buffer SHALL change only at frame boundaries, so no frame ever mixes data from two loads.
REQ-022 oFrame SHALL pulse high for exactly one cycle, the cycle after each frame boundary, whether or not a transfer occurred.
REQ-023 While prescaler < DEAD: oDIGIT=0 and oSEG7=0 (anti-ghosting).
REQ-024 While prescaler >= DEAD: oDIGIT has only bit [index] set; oSEG7 = decode(display nibble[index]), or 0 if that digit is blanked.
REQ-025 A digit SHALL be blanked if its display mask bit = 1, or if it is suppressed by leading-zero suppression.
REQ-026 Leading-zero suppression: when iLzs=1, digits from N_DIGITS-1 downward whose nibble = 0 SHALL be suppressed up to, but not including, the first nonzero nibble; digit 0 SHALL never be suppressed.
REQ-027 oDIGIT and oSEG7 SHALL be registered: one cycle of latency from prescaler/index state, with no combinational path from inputs to outputs.

Reset
REQ-028 While reset_n=0: prescaler=0, index=0, both buffers=0, masks=0, oPending=0, oFrame=0, oDIGIT=0, oSEG7=0.
REQ-029 Reset asserted mid-frame or mid-pending SHALL discard the pending data immediately.
REQ-030 After release, scanning SHALL restart from digit 0 with a full DEAD interval.

Structure
REQ-031 A shared package SHALL hold the 7-bit segment constants for 0..F, the blank constant, and the parameter limits.
REQ-032 The block SHALL instantiate the existing seg_dec as its single sub-module for nibble decoding.
REQ-033 The block SHALL use no other sub-modules; the prescaler, index counter, buffers and suppression logic SHALL live in seg7_scan_driver.

Verification (N_DIGITS=4, SCAN_DIV=8, DEAD=2)
REQ-034 Reset, then load iHexBus=16'h12AF, iBlank=0 -> after the first boundary, the digit-0 slot shows oDIGIT=4'b0001 and oSEG7=seg_dec(F), and the digit-3 slot shows seg_dec(1); cycles 0-1 of each slot show oDIGIT=0.
REQ-035 Load 16'h0042 with iLzs=1 -> digits 3 and 2 show oSEG7=0; digits 1 and 0 show seg_dec(4) and seg_dec(2). Load 16'h0000 -> only digit 0 lit, showing 7'h3F.
REQ-036 Load 16'h1111, then 16'h2222 within the same frame -> oPending=1 until the boundary; the next frame shows only 2s; 1s are never displayed.
REQ-037 Assert iLoad on the exact boundary cycle with 16'h5555 -> oPending=0 the next cycle; the next frame shows 5s; oFrame pulses once.
REQ-038 iBlank=4'b0100 with data 16'h8888 -> the digit-2 slot has oDIGIT=4'b0100 and oSEG7=0; other digits show seg_dec(8).
REQ-039 Drop reset_n mid-slot with oPending=1 -> all outputs 0 asynchronously; after release, blank display, oPending=0, scan resumes at digit 0.
